bus_gate_arbiter: RTL and testbench



---
 rtl/bus_gate_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bus_gate_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bus_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_gate_arbiter
// Description : Round-robin arbiter driving the four datapath bus gate
//               selects (MARMUX, PC, MDR, ALU). It grants one source at a
//               time, limits how long an owner may hold the bus while others
//               wait, and keeps the registered gates one-hot or all-zero.
//               Optional macro BUS_ARB_TURNAROUND_EN inserts a one-cycle
//               all-zero TURN state on every ownership change.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_gate_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] req,
    input  logic       lock,
    output logic       GateMARMUX,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic [1:0] grant_id,
    output logic       bus_busy,
    output logic       preempt
);

    // Hold count value on which a waited-on owner is released, and the
    // saturation value of the counter.
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef BUS_ARB_TURNAROUND_EN
        ST_TURN  = 2'd2,
`endif
        ST_GRANT = 2'd1
    } state_t;

    state_t           state,     state_nxt;
    logic [3:0]       grant_oh,  grant_nxt;
    logic [1:0]       owner,     owner_nxt;
    logic [1:0]       last_id,   last_nxt;
    logic [CNT_W-1:0] hold_cnt,  hold_nxt;
    logic             preempt_q, preempt_nxt;
`ifdef BUS_ARB_TURNAROUND_EN
    logic [1:0]       next_id,   next_id_nxt;
`endif

    logic       owner_req;
    logic [3:0] others;
    logic       others_pend;
    logic       release_now;
    logic [1:0] win;

    // First set bit of vec searching base+1, base+2, base+3, base+0.
    function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] vec);
        logic [1:0] idx;
        rr_pick = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (vec[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] id);
        onehot = 4'b0001 << id;
    endfunction

    assign owner_req   = req[owner];
    assign others      = req & ~onehot(owner);
    assign others_pend = |others;
    // Preempt is also gated by the previous pulse so it can never fire on
    // back-to-back cycles, even with MAX_HOLD of 1.
    assign release_now = !owner_req ||
                         (others_pend && !lock && !preempt_q && (hold_cnt >= HOLD_LIM));

    // Next-state and next-register decode; defaults hold every register.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_oh;
        owner_nxt   = owner;
        last_nxt    = last_id;
        hold_nxt    = hold_cnt;
        preempt_nxt = 1'b0;
        win         = 2'd0;
`ifdef BUS_ARB_TURNAROUND_EN
        next_id_nxt = next_id;
`endif
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    win       = rr_pick(last_id, req);
                    state_nxt = ST_GRANT;
                    owner_nxt = win;
                    last_nxt  = win;
                    hold_nxt  = '0;
                    grant_nxt = onehot(win);
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    // Owner still requesting here means a forced release.
                    preempt_nxt = owner_req;
                    hold_nxt    = '0;
                    if (others_pend) begin
                        win = rr_pick(owner, others);
`ifdef BUS_ARB_TURNAROUND_EN
                        state_nxt   = ST_TURN;
                        next_id_nxt = win;
                        grant_nxt   = 4'b0000;
`else
                        owner_nxt   = win;
                        last_nxt    = win;
                        grant_nxt   = onehot(win);
`endif
                    end else begin
                        state_nxt = ST_IDLE;
                        grant_nxt = 4'b0000;
                    end
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
`ifdef BUS_ARB_TURNAROUND_EN
            ST_TURN: begin
                // Winner was latched on entry; requests seen here are ignored.
                state_nxt = ST_GRANT;
                owner_nxt = next_id;
                last_nxt  = next_id;
                hold_nxt  = '0;
                grant_nxt = onehot(next_id);
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = 4'b0000;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            grant_oh  <= 4'b0000;
            owner     <= 2'd0;
            last_id   <= 2'd3;
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
`ifdef BUS_ARB_TURNAROUND_EN
            next_id   <= 2'd0;
`endif
        end else begin
            state     <= state_nxt;
            grant_oh  <= grant_nxt;
            owner     <= owner_nxt;
            last_id   <= last_nxt;
            hold_cnt  <= hold_nxt;
            preempt_q <= preempt_nxt;
`ifdef BUS_ARB_TURNAROUND_EN
            next_id   <= next_id_nxt;
`endif
        end
    end

    assign GateMARMUX = grant_oh[0];
    assign GatePC     = grant_oh[1];
    assign GateMDR    = grant_oh[2];
    assign GateALU    = grant_oh[3];
    assign grant_id   = owner;
    assign bus_busy   = |grant_oh;
    assign preempt    = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_gate_arbiter
// Description : Directed self-checking bench for bus_gate_arbiter with the
//               default build (no turnaround state), MAX_HOLD=4, CNT_W=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_gate_arbiter;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [3:0] req;
    logic       lock;
    logic       GateMARMUX, GatePC, GateMDR, GateALU;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       preempt;
    logic [3:0] gates;

    int checks = 0;
    int errors = 0;

    bus_gate_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req        (req),
        .lock       (lock),
        .GateMARMUX (GateMARMUX),
        .GatePC     (GatePC),
        .GateMDR    (GateMDR),
        .GateALU    (GateALU),
        .grant_id   (grant_id),
        .bus_busy   (bus_busy),
        .preempt    (preempt)
    );

    assign gates = {GateALU, GateMDR, GatePC, GateMARMUX};

    // 100 MHz clock.
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        req     = 4'b1111;
        lock    = 1'b0;

        // Reset held two cycles with every source requesting.
        tick();
        tick();
        check("rst_gates",   32'(gates),    32'h0);
        check("rst_busy",    32'(bus_busy), 32'h0);
        check("rst_preempt", 32'(preempt),  32'h0);
        check("rst_id",      32'(grant_id), 32'h0);
        Reset_n = 1'b1;

        // Round robin with all requesting: 0,1,2,3,0 each for 4 cycles.
        for (int k = 0; k < 20; k++) begin
            tick();
            check("rr_gates",   32'(gates),    32'(4'b0001 << ((k / 4) % 4)));
            check("rr_id",      32'(grant_id), 32'((k / 4) % 4));
            check("rr_preempt", 32'(preempt),  32'((k % 4 == 0) && (k > 0)));
            check("rr_busy",    32'(bus_busy), 32'h1);
        end

        // Single requester MDR: MARMUX drops, MDR takes over back-to-back.
        req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("single_gates",   32'(gates),   32'h4);
            check("single_preempt", 32'(preempt), 32'h0);
        end
        req = 4'b0000;
        tick();
        check("single_drop_gates", 32'(gates),    32'h0);
        check("single_drop_busy",  32'(bus_busy), 32'h0);
        tick();
        check("idle_gates", 32'(gates), 32'h0);

        // Lock: PC owner keeps the bus past MAX_HOLD while MARMUX waits.
        req = 4'b0010;
        tick();
        check("lock_grant_gates", 32'(gates),    32'h2);
        check("lock_grant_id",    32'(grant_id), 32'h1);
        req  = 4'b0011;
        lock = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("lock_hold_gates",   32'(gates),   32'h2);
            check("lock_hold_preempt", 32'(preempt), 32'h0);
        end
        lock = 1'b0;
        tick();
        check("unlock_gates",   32'(gates),    32'h1);
        check("unlock_id",      32'(grant_id), 32'h0);
        check("unlock_preempt", 32'(preempt),  32'h1);
        tick();
        check("preempt_once", 32'(preempt), 32'h0);
        check("after_unlock", 32'(gates),   32'h1);

        // Voluntary release: MARMUX -> ALU, then ALU -> PC with no gap.
        req = 4'b1000;
        tick();
        check("vol_alu_gates",   32'(gates),    32'h8);
        check("vol_alu_id",      32'(grant_id), 32'h3);
        check("vol_alu_preempt", 32'(preempt),  32'h0);
        req = 4'b1010;
        tick();
        check("vol_alu_hold", 32'(gates), 32'h8);
        req = 4'b0010;
        tick();
        check("vol_pc_gates",   32'(gates),    32'h2);
        check("vol_pc_preempt", 32'(preempt),  32'h0);
        check("vol_pc_id",      32'(grant_id), 32'h1);

        // Mid-grant reset during an MDR grant.
        req = 4'b0100;
        tick();
        check("mid_mdr_gates", 32'(gates), 32'h4);
        Reset_n = 1'b0;
        tick();
        check("mid_rst_gates",   32'(gates),    32'h0);
        check("mid_rst_busy",    32'(bus_busy), 32'h0);
        check("mid_rst_preempt", 32'(preempt),  32'h0);
        Reset_n = 1'b1;
        tick();
        check("post_rst_gates", 32'(gates),    32'h4);
        check("post_rst_id",    32'(grant_id), 32'h2);

        // Pointer restarts at 3: with ALU and MARMUX requesting, MARMUX wins.
        Reset_n = 1'b0;
        req     = 4'b1001;
        tick();
        check("rst2_gates", 32'(gates), 32'h0);
        Reset_n = 1'b1;
        tick();
        check("ptr_gates", 32'(gates),    32'h1);
        check("ptr_id",    32'(grant_id), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
